// File: rtl/au_flag_pkg.sv
// Shared encodings for the AU flag unit: condition codes, result classes, FSM states and
// flag bit positions.
package au_flag_pkg;

  localparam logic [2:0] COND_NE     = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_OVF    = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_Z    = 2'b01;
  localparam logic [1:0] CLS_ZVN  = 2'b10;

  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_N = 0;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StWait    = 2'b01,
    StResolve = 2'b10
  } fsm_state_e;

  // Class 11 is reserved and behaves like CLS_NONE.
  function automatic logic writes_flags(logic [1:0] cls);
    return (cls == CLS_Z) || (cls == CLS_ZVN);
  endfunction

endpackage

// File: rtl/au_flag_unit_if.sv
// Result/flag and branch-condition bus between the execute stage, branch logic and the
// flag unit.
interface au_flag_unit_if;
  logic        issue_fw;
  logic        issue_stall;
  logic        res_valid;
  logic [1:0]  res_class;
  logic [15:0] res_data;
  logic        res_v;
  logic        res_n;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic        br_resp_valid;
  logic        br_taken;
  logic [2:0]  flags;
  logic        err_underflow;

  modport master (
    output issue_fw, res_valid, res_class, res_data, res_v, res_n, br_valid, br_cond,
    input  issue_stall, br_ready, br_resp_valid, br_taken, flags, err_underflow
  );

  modport slave (
    input  issue_fw, res_valid, res_class, res_data, res_v, res_n, br_valid, br_cond,
    output issue_stall, br_ready, br_resp_valid, br_taken, flags, err_underflow
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Pure combinational branch-condition evaluator over a {Z,V,N} flag vector; shared with the
// decode-stage predictor.
module branch_cond_eval
  import au_flag_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[FLG_Z];
  assign v = flags[FLG_V];
  assign n = flags[FLG_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE:     taken = ~z;
      COND_EQ:     taken = z;
      COND_GT:     taken = ~z & ~n;
      COND_LT:     taken = n;
      COND_GE:     taken = z | ~n;
      COND_LE:     taken = z | n;
      COND_OVF:    taken = v;
      COND_UNCOND: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/au_flag_unit.sv
// Flag register, in-flight flag-writer counter and branch-condition resolver at the consumer
// end of the AU result bus.
module au_flag_unit
  import au_flag_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input logic           clk,
  input logic           rst,
  au_flag_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] pending_q, pending_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       cond_q, cond_d;
  logic             err_q, err_d;
  fsm_state_e       state_q, state_d;

  logic stall, inc, dec, br_ready, resp_valid, taken_raw;

  // Younger flag writers are held while a branch resolves so the answer cannot see them.
  assign stall = (pending_q == MaxCnt) | (state_q != StIdle);
  assign inc   = bus.issue_fw & ~stall;
  assign dec   = bus.res_valid & writes_flags(bus.res_class);

  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (inc && !dec) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (pending_q == '0) err_d = 1'b1;
      else                 pending_d = pending_q - CNT_W'(1);
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (bus.res_valid) begin
      case (bus.res_class)
        CLS_Z: flags_d[FLG_Z] = (bus.res_data == 16'h0000);
        CLS_ZVN: begin
          flags_d[FLG_Z] = (bus.res_data == 16'h0000);
          flags_d[FLG_V] = bus.res_v;
          flags_d[FLG_N] = bus.res_n;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cond_d     = cond_q;
    br_ready   = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      StIdle: begin
        br_ready = 1'b1;
        if (bus.br_valid) begin
          cond_d  = bus.br_cond;
          state_d = StWait;
        end
      end
      StWait: begin
        if (pending_q == '0) state_d = StResolve;
      end
      StResolve: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  branch_cond_eval u_cond_eval (
    .cond  (cond_q),
    .flags (flags_q),
    .taken (taken_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      flags_q   <= 3'b000;
      cond_q    <= COND_NE;
      err_q     <= 1'b0;
      state_q   <= StIdle;
    end else begin
      pending_q <= pending_d;
      flags_q   <= flags_d;
      cond_q    <= cond_d;
      err_q     <= err_d;
      state_q   <= state_d;
    end
  end

  assign bus.issue_stall   = stall;
  assign bus.br_ready      = br_ready;
  assign bus.br_resp_valid = resp_valid;
  assign bus.br_taken      = resp_valid & taken_raw;
  assign bus.flags         = flags_q;
  assign bus.err_underflow = err_q;

endmodule
